// File: rtl/hex_display_sched_pkg.sv
// Shared types and the round-robin pick helper for hex_display_sched.
package hex_display_sched_pkg;

  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned IDX_W   = 5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SHOW = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First requester at or after ptr (wrapping at nreq) with req and mask both set.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [MAX_REQ-1:0] mask,
                                    input int unsigned        nreq,
                                    input int unsigned        ptr);
    pick_t       r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < nreq && !r.found) begin
        j = ptr + i;
        if (j >= nreq) j = j - nreq;
        if (req[IDX_W'(j)] && mask[IDX_W'(j)]) begin
          r.found = 1'b1;
          r.idx   = IDX_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_display_sched_hexdriver.sv
// One seven-segment digit decoder: 4-bit hex in, active-low segments {g,f,e,d,c,b,a} out.
module hex_display_sched_hexdriver
  import hex_display_sched_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_sched.sv
// Round-robin time-sharing of a seven-segment digit bank between NREQ requesters.
// Optional build macro HEX_LEAD_ZERO_BLANK_EN blanks leading zero digits while showing.
module hex_display_sched
  import hex_display_sched_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*4*DIGITS-1:0]     data,
  output logic [NREQ-1:0]              grant,
  output logic [$clog2(NREQ)-1:0]      owner,
  output logic                         busy,
  output logic [DIGITS*7-1:0]          HEX
);

  localparam int unsigned OW    = $clog2(NREQ);
  localparam int unsigned DW    = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

`ifdef HEX_LEAD_ZERO_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  state_t             r_state;
  logic [OW-1:0]      r_rr_ptr;
  logic [OW-1:0]      r_owner;
  logic [NREQ-1:0]    r_grant;
  logic               r_busy;
  logic [CNT_W-1:0]   r_hold;
  logic [DW-1:0]      r_disp;
  logic [DIGITS-1:0]  r_blank;

  logic [MAX_REQ-1:0] w_req_ext;
  pick_t              w_pick_any;
  pick_t              w_pick_oth;
  logic               w_owner_req;
  logic               w_do_grant;
  logic               w_go_idle;
  logic [OW-1:0]      w_gnt_idx;
  logic [DW-1:0]      w_gnt_data;
  logic [DW-1:0]      w_own_data;

  function automatic logic [DW-1:0] f_sel(input logic [NREQ*DW-1:0] d,
                                          input logic [OW-1:0]      idx);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (idx == OW'(i)) r = d[i*DW +: DW];
    end
    return r;
  endfunction

  // Digits above the most-significant nonzero nibble; digit 0 always shown.
  function automatic logic [DIGITS-1:0] f_blank(input logic [DW-1:0] v);
    logic [DIGITS-1:0] m;
    logic              seen;
    m    = '0;
    seen = 1'b0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (v[k*4 +: 4] != 4'h0) seen = 1'b1;
      m[k] = ~seen;
    end
    return LZ_EN ? m : '0;
  endfunction

  function automatic logic [OW-1:0] f_inc(input logic [OW-1:0] i);
    return (32'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  assign w_req_ext   = MAX_REQ'(req);
  assign w_pick_any  = rr_pick(w_req_ext, {MAX_REQ{1'b1}}, NREQ, 32'(r_rr_ptr));
  assign w_pick_oth  = rr_pick(w_req_ext, ~(MAX_REQ'(1) << r_owner), NREQ, 32'(r_rr_ptr));
  assign w_owner_req = req[r_owner];
  assign w_gnt_data  = f_sel(data, w_gnt_idx);
  assign w_own_data  = f_sel(data, r_owner);

  // Arbitration decision; an owner drop takes precedence over hold expiry.
  always_comb begin
    w_do_grant = 1'b0;
    w_go_idle  = 1'b0;
    w_gnt_idx  = '0;
    case (r_state)
      S_IDLE: begin
        w_do_grant = w_pick_any.found;
        w_gnt_idx  = OW'(w_pick_any.idx);
      end
      S_SHOW: begin
        w_gnt_idx = OW'(w_pick_oth.idx);
        if (!w_owner_req) begin
          w_do_grant = w_pick_oth.found;
          w_go_idle  = !w_pick_oth.found;
        end else begin
          w_do_grant = (r_hold == '0) && w_pick_oth.found;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_hold   <= '0;
      r_disp   <= '0;
      r_blank  <= '1;
    end else if (w_do_grant) begin
      r_state  <= S_SHOW;
      r_owner  <= w_gnt_idx;
      r_grant  <= NREQ'(1) << w_gnt_idx;
      r_busy   <= 1'b1;
      r_hold   <= HOLD_LOAD;
      r_rr_ptr <= f_inc(w_gnt_idx);
      r_disp   <= w_gnt_data;
      r_blank  <= f_blank(w_gnt_data);
    end else begin
      case (r_state)
        S_IDLE: begin
          r_blank <= '1;
        end
        S_SHOW: begin
          if (w_go_idle) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_blank <= '1;
          end else begin
            r_disp  <= w_own_data;
            r_blank <= f_blank(w_own_data);
            if (r_hold != '0) r_hold <= r_hold - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign owner = r_owner;
  assign busy  = r_busy;

  logic [6:0] w_seg [DIGITS];

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_dig
    hex_display_sched_hexdriver u_hexdriver (
      .i_nib (r_disp[k*4 +: 4]),
      .o_seg (w_seg[k])
    );
    assign HEX[k*7 +: 7] = r_blank[k] ? SEG_BLANK : w_seg[k];
  end

endmodule
